// File: rtl/comb_sweep_pkg.sv
// Shared types and constants for the exhaustive truth-table sweep sequencer.
// The signature helper is only used when COMB_SWEEP_MISR_EN is defined.
package comb_sweep_pkg;

  localparam int SIG_W = 32;
  localparam logic [SIG_W-1:0] MISR_POLY = 32'h04C11DB7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_WAIT,
    ST_CAPTURE,
    ST_EMIT,
    ST_DONE
  } state_t;

  // One MISR step: shift left, fold the polynomial on carry-out, then mix in the row.
  function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] sig,
                                                 input logic [SIG_W-1:0] din);
    return {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0) ^ din;
  endfunction

endpackage

// File: rtl/comb_sweep_sequencer_if.sv
// Captured-row stream between the sweep sequencer and its consumer.
// Plain valid/ready handshake; idx/data are stable while valid is high.
interface comb_sweep_sequencer_if #(
  parameter int IN_W  = 4,
  parameter int OUT_W = 18
);
  logic             row_valid;
  logic             row_ready;
  logic [IN_W-1:0]  row_idx;
  logic [OUT_W-1:0] row_data;

  modport master (output row_valid, output row_idx, output row_data, input row_ready);
  modport slave  (input row_valid, input row_idx, input row_data, output row_ready);
endinterface

// File: rtl/comb_sweep_misr.sv
// 32-bit multiple-input signature register folding one truth-table row per enable.
// Instantiated by the sequencer only when COMB_SWEEP_MISR_EN is defined.
module comb_sweep_misr
  import comb_sweep_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [DATA_W-1:0] data,
  output logic [SIG_W-1:0]  sig
);

  logic [SIG_W-1:0] sig_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sig_reg <= '0;
    end else if (clr) begin
      sig_reg <= '0;
    end else if (en) begin
      sig_reg <= misr_next(sig_reg, SIG_W'(data));
    end
  end

  assign sig = sig_reg;

endmodule

// File: rtl/comb_sweep_sequencer.sv
// Drives every input vector into an attached combinational netlist, waits SETTLE
// cycles, captures its outputs and streams each row out. Optional COMB_SWEEP_MISR_EN.
module comb_sweep_sequencer
  import comb_sweep_pkg::*;
#(
  parameter int IN_W   = 4,
  parameter int OUT_W  = 18,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [IN_W-1:0]        dut_x,
  input  logic [OUT_W-1:0]       dut_f,
  comb_sweep_sequencer_if.master row,
  output logic [SIG_W-1:0]       signature
);

  localparam int ROWS_M1 = (1 << IN_W) - 1;
  localparam logic [IN_W:0] LAST_IDX = (IN_W + 1)'(ROWS_M1);
  localparam logic [3:0] SETTLE_M1 = 4'((SETTLE == 0) ? 0 : SETTLE - 1);

  state_t           state_reg;
  logic [IN_W:0]    idx_reg;
  logic [3:0]       settle_cnt_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             row_valid_reg;
  logic [IN_W-1:0]  dut_x_reg;
  logic [IN_W-1:0]  row_idx_reg;
  logic [OUT_W-1:0] row_data_reg;
  logic             start_ok;

  // Abort beats a simultaneous start, so a sweep only begins on a clean start.
  assign start_ok = (state_reg == ST_IDLE) && start && !abort;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      settle_cnt_reg <= '0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
      row_valid_reg  <= 1'b0;
      dut_x_reg      <= '0;
      row_idx_reg    <= '0;
      row_data_reg   <= '0;
    end else begin
      done_reg <= 1'b0;
      if (state_reg != ST_IDLE && abort) begin
        state_reg     <= ST_IDLE;
        busy_reg      <= 1'b0;
        row_valid_reg <= 1'b0;
      end else begin
        case (state_reg)
          ST_IDLE: begin
            if (start_ok) begin
              state_reg <= ST_APPLY;
              idx_reg   <= '0;
              busy_reg  <= 1'b1;
            end
          end
          ST_APPLY: begin
            dut_x_reg      <= idx_reg[IN_W-1:0];
            settle_cnt_reg <= '0;
            state_reg      <= (SETTLE == 0) ? ST_CAPTURE : ST_WAIT;
          end
          ST_WAIT: begin
            if (settle_cnt_reg == SETTLE_M1) begin
              state_reg <= ST_CAPTURE;
            end else begin
              settle_cnt_reg <= settle_cnt_reg + 4'd1;
            end
          end
          ST_CAPTURE: begin
            row_data_reg  <= dut_f;
            row_idx_reg   <= idx_reg[IN_W-1:0];
            row_valid_reg <= 1'b1;
            state_reg     <= ST_EMIT;
          end
          ST_EMIT: begin
            if (row.row_ready) begin
              row_valid_reg <= 1'b0;
              if (idx_reg == LAST_IDX) begin
                state_reg <= ST_DONE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                idx_reg   <= idx_reg + 1'b1;
                state_reg <= ST_APPLY;
              end
            end
          end
          ST_DONE: begin
            state_reg <= ST_IDLE;
          end
          default: begin
            state_reg <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign busy          = busy_reg;
  assign done          = done_reg;
  assign dut_x         = dut_x_reg;
  assign row.row_valid = row_valid_reg;
  assign row.row_idx   = row_idx_reg;
  assign row.row_data  = row_data_reg;

`ifdef COMB_SWEEP_MISR_EN
  logic row_fire;

  // Only a delivered row (handshake without abort) enters the signature.
  assign row_fire = (state_reg == ST_EMIT) && row_valid_reg && row.row_ready && !abort;

  comb_sweep_misr #(
    .DATA_W (OUT_W)
  ) u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (start_ok),
    .en    (row_fire),
    .data  (row_data_reg),
    .sig   (signature)
  );
`else
  assign signature = '0;
`endif

endmodule

// File: tb/tb_comb_sweep_sequencer.sv
// Directed bench for comb_sweep_sequencer: identity and inverting stubs, backpressure,
// abort, ignored start and mid-sweep reset. Expected signature follows COMB_SWEEP_MISR_EN.
module tb_comb_sweep_sequencer;

  localparam int IN_W  = 4;
  localparam int OUT_W = 18;
  localparam int ROWS  = 16;
`ifdef COMB_SWEEP_MISR_EN
  localparam bit MISR_ON = 1'b1;
`else
  localparam bit MISR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             start_a, abort_a, busy_a, done_a;
  logic [IN_W-1:0]  x_a;
  logic [OUT_W-1:0] f_a;
  logic [31:0]      sig_a;
  logic             start_b, abort_b, busy_b, done_b;
  logic [IN_W-1:0]  x_b;
  logic [OUT_W-1:0] f_b;
  logic [31:0]      sig_b;

  comb_sweep_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) row_a_if ();
  comb_sweep_sequencer_if #(.IN_W(IN_W), .OUT_W(OUT_W)) row_b_if ();

  assign f_a = {14'b0, x_a};
  assign f_b = ~{14'b0, x_b};

  comb_sweep_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(1)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_a),
    .abort     (abort_a),
    .busy      (busy_a),
    .done      (done_a),
    .dut_x     (x_a),
    .dut_f     (f_a),
    .row       (row_a_if),
    .signature (sig_a)
  );

  comb_sweep_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(0)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_b),
    .abort     (abort_b),
    .busy      (busy_b),
    .done      (done_b),
    .dut_x     (x_b),
    .dut_f     (f_b),
    .row       (row_b_if),
    .signature (sig_b)
  );

  typedef struct {
    logic [IN_W-1:0]  idx;
    logic [OUT_W-1:0] f_id;
    logic [OUT_W-1:0] f_inv;
  } vec_t;

  vec_t             tbl [ROWS];
  int               n_cmp = 0;
  int               n_fail = 0;
  int               nrows, busy_cnt, done_at;
  logic [IN_W-1:0]  got_idx [64];
  logic [OUT_W-1:0] got_data [64];
  bit               cut;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] sig_model(input int nr, input bit inv);
    logic [31:0] s;
    s = '0;
    for (int i = 0; i < nr; i++) begin
      s = {s[30:0], 1'b0} ^ (s[31] ? 32'h04C11DB7 : 32'h0) ^
          {14'b0, (inv ? tbl[i].f_inv : tbl[i].f_id)};
    end
    return MISR_ON ? s : 32'h0;
  endfunction

  // Runs one sweep on DUT A; optional stall, start pulse, and abort/reset cut at given rows.
  task automatic sweep_a(input int stall_row, input int stall_len, input int cut_row,
                         input bit cut_rst, input int pulse_row, output bit was_cut);
    int  stall_left;
    bit  pulsed;
    nrows = 0; busy_cnt = 0; done_at = 0; was_cut = 1'b0;
    stall_left = stall_len; pulsed = 1'b0;
    row_a_if.row_ready = 1'b1;
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("sig_cleared_on_start", sig_a, 32'h0);
    for (int k = 1; k <= 300 && done_at == 0 && !was_cut; k++) begin
      if (busy_a) busy_cnt++;
      if (done_a) done_at = k;
      start_a = 1'b0;
      if (row_a_if.row_valid && int'(row_a_if.row_idx) == pulse_row && !pulsed) begin
        start_a = 1'b1;
        pulsed  = 1'b1;
      end
      if (row_a_if.row_valid && int'(row_a_if.row_idx) == stall_row && stall_left > 0) begin
        row_a_if.row_ready = 1'b0;
        stall_left--;
        chk("stall_row_idx", 32'(row_a_if.row_idx), 32'(tbl[stall_row].idx));
        chk("stall_row_data", 32'(row_a_if.row_data), 32'(tbl[stall_row].f_id));
      end else begin
        row_a_if.row_ready = 1'b1;
      end
      if (row_a_if.row_valid && int'(row_a_if.row_idx) == cut_row) begin
        if (cut_rst) rst_n = 1'b0;
        else abort_a = 1'b1;
        was_cut = 1'b1;
      end else if (row_a_if.row_valid && row_a_if.row_ready && nrows < 64) begin
        got_idx[nrows]  = row_a_if.row_idx;
        got_data[nrows] = row_a_if.row_data;
        nrows++;
      end
      step();
    end
    start_a = 1'b0;
  endtask

  task automatic check_rows(input int exp_n);
    chk("row_count", 32'(nrows), 32'(exp_n));
    for (int i = 0; i < nrows && i < ROWS; i++) begin
      chk($sformatf("row%0d_idx", i), 32'(got_idx[i]), 32'(tbl[i].idx));
      chk($sformatf("row%0d_data", i), 32'(got_data[i]), 32'(tbl[i].f_id));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy_a), 32'h0);
    chk({tag, "_done"}, 32'(done_a), 32'h0);
    chk({tag, "_row_valid"}, 32'(row_a_if.row_valid), 32'h0);
    chk({tag, "_dut_x"}, 32'(x_a), 32'h0);
    chk({tag, "_row_idx"}, 32'(row_a_if.row_idx), 32'h0);
    chk({tag, "_row_data"}, 32'(row_a_if.row_data), 32'h0);
    chk({tag, "_signature"}, sig_a, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < ROWS; i++) begin
      tbl[i].idx   = 4'(i);
      tbl[i].f_id  = 18'(i);
      tbl[i].f_inv = 18'h3FFFF ^ 18'(i);
    end
    rst_n = 1'b0;
    start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
    row_a_if.row_ready = 1'b1;
    row_b_if.row_ready = 1'b1;
    repeat (3) step();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    step();

    // start and abort together in IDLE: abort wins
    start_a = 1'b1; abort_a = 1'b1;
    step();
    start_a = 1'b0; abort_a = 1'b0;
    step();
    chk("start_abort_idle_busy", 32'(busy_a), 32'h0);
    $display("txn idle start+abort: busy=%0b", busy_a);

    // full identity sweep, SETTLE=1
    sweep_a(-1, 0, -1, 1'b0, -1, cut);
    chk("full_busy_cycles", 32'(busy_cnt), 32'd64);
    chk("full_done_cycle", 32'(done_at), 32'd65);
    check_rows(16);
    chk("full_signature", sig_a, sig_model(16, 1'b0));
    chk("full_done_pulse_width", 32'(done_a), 32'h0);
    chk("full_dut_x_retained", 32'(x_a), 32'hF);
    $display("txn full sweep: rows=%0d busy=%0d done_at=%0d sig=%08h", nrows, busy_cnt, done_at, sig_a);

    // backpressure on row 3 for 5 cycles
    sweep_a(3, 5, -1, 1'b0, -1, cut);
    chk("bp_busy_cycles", 32'(busy_cnt), 32'd69);
    chk("bp_done_cycle", 32'(done_at), 32'd70);
    check_rows(16);
    chk("bp_signature", sig_a, sig_model(16, 1'b0));
    $display("txn backpressure sweep: rows=%0d busy=%0d done_at=%0d", nrows, busy_cnt, done_at);

    // SETTLE=0 inverting stub on DUT B
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    nrows = 0; busy_cnt = 0; done_at = 0;
    for (int k = 1; k <= 200 && done_at == 0; k++) begin
      if (busy_b) busy_cnt++;
      if (done_b) done_at = k;
      if (row_b_if.row_valid && row_b_if.row_ready && nrows < 64) begin
        got_idx[nrows]  = row_b_if.row_idx;
        got_data[nrows] = row_b_if.row_data;
        nrows++;
      end
      step();
    end
    chk("s0_busy_cycles", 32'(busy_cnt), 32'd48);
    chk("s0_done_cycle", 32'(done_at), 32'd49);
    chk("s0_row_count", 32'(nrows), 32'd16);
    for (int i = 0; i < nrows && i < ROWS; i++) begin
      chk($sformatf("s0_row%0d_idx", i), 32'(got_idx[i]), 32'(tbl[i].idx));
      chk($sformatf("s0_row%0d_data", i), 32'(got_data[i]), 32'(tbl[i].f_inv));
    end
    chk("s0_signature", sig_b, sig_model(16, 1'b1));
    $display("txn settle0 sweep: rows=%0d busy=%0d done_at=%0d", nrows, busy_cnt, done_at);

    // abort while row 7 is presented
    sweep_a(-1, 0, 7, 1'b0, -1, cut);
    chk("abort_reached", 32'(cut), 32'h1);
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_row_valid", 32'(row_a_if.row_valid), 32'h0);
    chk("abort_done", 32'(done_a), 32'h0);
    abort_a = 1'b0;
    check_rows(7);
    chk("abort_signature_partial", sig_a, sig_model(7, 1'b0));
    for (int k = 0; k < 3; k++) begin
      step();
      chk("abort_no_done", 32'(done_a), 32'h0);
    end
    $display("txn abort at row 7: rows=%0d busy=%0d", nrows, busy_a);

    sweep_a(-1, 0, -1, 1'b0, -1, cut);
    check_rows(16);
    chk("restart_busy_cycles", 32'(busy_cnt), 32'd64);
    chk("restart_signature", sig_a, sig_model(16, 1'b0));
    $display("txn restart sweep: rows=%0d busy=%0d", nrows, busy_cnt);

    // start pulse mid-sweep is ignored; reset at row 9
    sweep_a(-1, 0, 9, 1'b1, 2, cut);
    chk("reset_reached", 32'(cut), 32'h1);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    check_rows(9);
    step();
    chk("midreset_idle", 32'(busy_a), 32'h0);
    $display("txn reset at row 9: rows=%0d", nrows);

    sweep_a(-1, 0, -1, 1'b0, -1, cut);
    check_rows(16);
    chk("post_reset_busy_cycles", 32'(busy_cnt), 32'd64);
    chk("post_reset_done_cycle", 32'(done_at), 32'd65);
    $display("txn post-reset sweep: rows=%0d busy=%0d done_at=%0d", nrows, busy_cnt, done_at);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
